// File: rtl/video_io_pkg.sv
// Shared types and board timing constants for the slide-switch input path
// in the fpga_CLK_AUX (27 MHz) domain.
package video_io_pkg;

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } sw_state_t;

  // Widest channel index an event can carry; the top uses the low ID_W bits.
  localparam int SW_ID_W = 4;

  typedef struct packed {
    logic [SW_ID_W-1:0] id;
    logic               dir;
  } sw_evt_t;

  localparam int DEBOUNCE_10MS_27M = 270_000;
  localparam int LONG_1S_27M       = 27_000_000;

endpackage

// File: rtl/sw_debounce_chan.sv
// One switch channel: 2-FF synchroniser, debounce FSM with saturating counter,
// registered edge pulses and, with SW_LONG_PRESS_EN, a long-press pulse.
module sw_debounce_chan
  import video_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_27M,
  parameter int LONG_CYCLES     = LONG_1S_27M
) (
  input  logic fpga_CLK_AUX,
  input  logic fpga_NRST,
  input  logic sw_raw,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall,
  output logic sw_long
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             sync;
  sw_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  assign sync_d = {sync_q[0], sw_raw};
  assign sync   = sync_q[1];

  always_ff @(posedge fpga_CLK_AUX or negedge fpga_NRST) begin
    if (!fpga_NRST) begin
      sync_q  <= '0;
      state_q <= ST_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Counter only advances below CNT_MAX, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_LO: begin
        if (sync) begin
          state_d = CHK_HI;
          cnt_d   = '0;
        end
      end
      CHK_HI: begin
        if (!sync) begin
          state_d = ST_LO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HI: begin
        if (!sync) begin
          state_d = CHK_LO;
          cnt_d   = '0;
        end
      end
      CHK_LO: begin
        if (sync) begin
          state_d = ST_HI;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_LO;
    endcase
  end

  assign sw_level = level_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;

`ifdef SW_LONG_PRESS_EN
  localparam int LONG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic              long_done_q, long_done_d;
  logic              long_q, long_d;

  always_ff @(posedge fpga_CLK_AUX or negedge fpga_NRST) begin
    if (!fpga_NRST) begin
      long_cnt_q  <= '0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      long_cnt_q  <= long_cnt_d;
      long_done_q <= long_done_d;
      long_q      <= long_d;
    end
  end

  // long_done survives a rejected release glitch so a press pulses only once.
  always_comb begin
    long_cnt_d  = '0;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if (state_q == ST_HI) begin
      if (long_cnt_q == LONG_MAX) begin
        long_cnt_d = long_cnt_q;
        if (!long_done_q) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
      end else begin
        long_cnt_d = long_cnt_q + 1'b1;
      end
    end
    if (state_q == ST_LO) long_done_d = 1'b0;
  end

  assign sw_long = long_q;
`else
  localparam int UNUSED_LONG_CYCLES = LONG_CYCLES;
  assign sw_long = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Debounced slide-switch inputs with a single-entry edge event register.
// Optional long-press pulses are built when SW_LONG_PRESS_EN is defined.
module sw_debounce
  import video_io_pkg::*;
#(
  parameter int N_SW            = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_27M,
  parameter int LONG_CYCLES     = LONG_1S_27M,
  parameter int ID_W            = (N_SW > 1) ? $clog2(N_SW) : 1
) (
  input  logic            fpga_CLK_AUX,
  input  logic            fpga_NRST,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  output logic            evt_dir,
  input  logic            evt_ready,
  output logic            evt_ovf,
  input  logic            evt_ovf_clr,
  output logic [N_SW-1:0] sw_long
);

  for (genvar g = 0; g < N_SW; g++) begin : g_chan
    sw_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_chan (
      .fpga_CLK_AUX(fpga_CLK_AUX),
      .fpga_NRST   (fpga_NRST),
      .sw_raw      (sw_raw[g]),
      .sw_level    (sw_level[g]),
      .sw_rise     (sw_rise[g]),
      .sw_fall     (sw_fall[g]),
      .sw_long     (sw_long[g])
    );
  end

  sw_evt_t         evt_q, evt_d, win;
  logic            evt_valid_q, evt_valid_d;
  logic            evt_ovf_q, evt_ovf_d;
  logic            found, multi, load, ovf_set;
  logic [N_SW-1:0] edge_vec;

  assign edge_vec = sw_rise | sw_fall;

  // Lowest-index edge wins; any further simultaneous edge is a drop.
  always_comb begin
    win   = '0;
    found = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N_SW; i++) begin
      if (edge_vec[i]) begin
        if (!found) begin
          found   = 1'b1;
          win.id  = SW_ID_W'(i);
          win.dir = sw_rise[i];
        end else begin
          multi = 1'b1;
        end
      end
    end
    load    = found && (!evt_valid_q || evt_ready);
    ovf_set = (found && evt_valid_q && !evt_ready) || multi;

    evt_d       = load ? win : evt_q;
    evt_valid_d = load ? 1'b1 : (evt_ready ? 1'b0 : evt_valid_q);
    evt_ovf_d   = ovf_set ? 1'b1 : (evt_ovf_clr ? 1'b0 : evt_ovf_q);
  end

  always_ff @(posedge fpga_CLK_AUX or negedge fpga_NRST) begin
    if (!fpga_NRST) begin
      evt_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_ovf_q   <= 1'b0;
    end else begin
      evt_q       <= evt_d;
      evt_valid_q <= evt_valid_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  logic unused_evt_id;
  assign unused_evt_id = ^evt_q.id;

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_q.id[ID_W-1:0];
  assign evt_dir   = evt_q.dir;
  assign evt_ovf   = evt_ovf_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=8, LONG_CYCLES=32.
module tb_sw_debounce;

  logic       clk = 1'b0;
  logic       nrst;
  logic [1:0] sw_raw;
  logic [1:0] sw_level, sw_rise, sw_fall, sw_long;
  logic       evt_valid, evt_id, evt_dir, evt_ready, evt_ovf, evt_ovf_clr;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] seen_pulse, seen_long;

  always #5 clk = ~clk;

  sw_debounce #(
    .N_SW           (2),
    .DEBOUNCE_CYCLES(8),
    .LONG_CYCLES    (32)
  ) dut (
    .fpga_CLK_AUX(clk),
    .fpga_NRST   (nrst),
    .sw_raw      (sw_raw),
    .sw_level    (sw_level),
    .sw_rise     (sw_rise),
    .sw_fall     (sw_fall),
    .evt_valid   (evt_valid),
    .evt_id      (evt_id),
    .evt_dir     (evt_dir),
    .evt_ready   (evt_ready),
    .evt_ovf     (evt_ovf),
    .evt_ovf_clr (evt_ovf_clr),
    .sw_long     (sw_long)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      seen_pulse = seen_pulse | sw_rise | sw_fall;
      seen_long  = seen_long | sw_long;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({sw_level, sw_rise, sw_fall, evt_valid, evt_id, evt_dir, evt_ovf, sw_long});
  endfunction

  initial begin
    nrst        = 1'b0;
    sw_raw      = 2'b00;
    evt_ready   = 1'b0;
    evt_ovf_clr = 1'b0;
    seen_pulse  = '0;
    seen_long   = '0;

    // 1: reset with toggling inputs, then quiet release
    for (int i = 0; i < 6; i++) begin
      sw_raw = ~sw_raw;
      tick(1);
    end
    chk("rst_outs", all_outs(), 32'h0);
    sw_raw = 2'b00;
    nrst   = 1'b1;
    seen_pulse = '0;
    tick(12);
    chk("idle_pulses", 32'(seen_pulse), 32'h0);
    chk("idle_state", all_outs(), 32'h0);

    // 2: ch0 rise, 10-cycle latency, event and handshake
    sw_raw = 2'b01;
    tick(10);
    chk("lat_pre_level", 32'(sw_level), 32'h0);
    tick(1);
    chk("lat_level", 32'(sw_level), 32'h1);
    chk("lat_rise", 32'(sw_rise), 32'h1);
    tick(1);
    chk("rise_1cyc", 32'(sw_rise), 32'h0);
    chk("evt_rise", 32'({evt_valid, evt_id, evt_dir}), 32'b101);
    evt_ready = 1'b1;
    tick(1);
    chk("evt_drain", 32'(evt_valid), 32'h0);
    evt_ready = 1'b0;

    // 3: short glitch on ch1
    seen_pulse = '0;
    sw_raw = 2'b11;
    tick(5);
    sw_raw = 2'b01;
    tick(15);
    chk("glitch_level", 32'(sw_level), 32'h1);
    chk("glitch_pulse", 32'(seen_pulse), 32'h0);
    chk("glitch_evt", 32'(evt_valid), 32'h0);

    // 4: ch0 fall event, then simultaneous rises and drops
    sw_raw = 2'b00;
    tick(11);
    chk("fall_pulse", 32'({sw_level, sw_fall}), 32'b0001);
    tick(1);
    chk("evt_fall", 32'({evt_valid, evt_id, evt_dir}), 32'b100);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("ovf_clean", 32'(evt_ovf), 32'h0);
    sw_raw = 2'b11;
    tick(11);
    chk("both_rise", 32'({sw_level, sw_rise}), 32'b1111);
    tick(1);
    chk("both_evt", 32'({evt_valid, evt_id, evt_dir}), 32'b101);
    chk("both_ovf", 32'(evt_ovf), 32'h1);
    evt_ovf_clr = 1'b1;
    tick(1);
    chk("ovf_clr", 32'(evt_ovf), 32'h0);
    sw_raw = 2'b10;
    tick(11);
    chk("drop_fall", 32'(sw_fall), 32'h1);
    tick(1);
    chk("drop_ovf_wins", 32'(evt_ovf), 32'h1);
    chk("evt_stable", 32'({evt_valid, evt_id, evt_dir}), 32'b101);
    tick(1);
    chk("ovf_clr2", 32'(evt_ovf), 32'h0);
    evt_ovf_clr = 1'b0;
    evt_ready   = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("drain2", 32'(evt_valid), 32'h0);

    // 5: reset mid-debounce restarts the full latency
    sw_raw = 2'b11;
    tick(7);
    nrst = 1'b0;
    #1;
    chk("mid_rst_outs", all_outs(), 32'h0);
    tick(2);
    nrst = 1'b1;
    tick(10);
    chk("rst_lat_pre", 32'(sw_level), 32'h0);
    tick(1);
    chk("rst_lat_level", 32'({sw_level, sw_rise}), 32'b1111);

    // 6: long press
`ifdef SW_LONG_PRESS_EN
    seen_long = '0;
    tick(31);
    chk("long_pre", 32'(seen_long), 32'h0);
    tick(1);
    chk("long_pulse", 32'(sw_long), 32'h3);
    seen_long = '0;
    tick(40);
    chk("long_once", 32'(seen_long), 32'h0);
    sw_raw = 2'b10;
    tick(11);
    sw_raw = 2'b11;
    tick(11);
    chk("repress_level", 32'(sw_level), 32'h3);
    seen_long = '0;
    tick(31);
    chk("long2_pre", 32'(seen_long), 32'h0);
    tick(1);
    chk("long2_pulse", 32'(sw_long), 32'h1);
`else
    seen_long = '0;
    tick(40);
    chk("long_off", 32'(seen_long), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
